add_sub_pipe: RTL and testbench
===============================

ADD_SUB_PIPE -- requirements
Module: add_sub_pipe

Interface
REQ-001 Parameter WIDTH, default 16, operand and result width in bits; SHALL be a multiple of SEG, >= SEG.
REQ-002 Parameter SEG, default 4, bits added per pipeline stage; NSTG = WIDTH/SEG stages.
REQ-003 Port CLK  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port RST_N  input  1  reset, synchronous, active-low.
REQ-005 Port in_valid  input  1  operand set present this cycle.
REQ-006 Port in_ready  output  1  block can accept an operand set this cycle.
REQ-007 Port a  input  WIDTH  operand A.
REQ-008 Port b  input  WIDTH  operand B.
REQ-009 Port c_in  input  1  carry-in, used in add mode only.
REQ-010 Port sub  input  1  mode: 0 = a+b+c_in, 1 = a-b.
REQ-011 Port out_valid  output  1  result present.
REQ-012 Port out_ready  input  1  consumer accepts result this cycle.
REQ-013 Port s  output  WIDTH  sum/difference.
REQ-014 Port c_out  output  1  carry out of MSB; in sub mode 1 = no borrow.
REQ-015 Port ovf  output  1  two's-complement signed overflow.

Function
REQ-016 Transfer in: operand set SHALL be accepted when in_valid && in_ready; a, b, c_in, sub captured together.
REQ-017 Sub mode SHALL compute a + ~b + 1 with c_in ignored; add mode computes a + b + c_in.
REQ-018 Stage k (0..NSTG-1) SHALL add bits [k*SEG +: SEG] using the registered carry from stage k-1 (stage 0 uses the mode carry); the unconsumed upper segments and completed lower segments are carried forward in registers alongside.
REQ-019 Latency: an accepted set SHALL appear on s/c_out/ovf with out_valid=1 exactly NSTG cycles after acceptance when no stall occurs.
REQ-020 Throughput: one set per cycle SHALL be sustained while out_ready=1.
REQ-021 Stall = out_valid && !out_ready; during stall every stage register, valid bit and output SHALL hold; in_ready = !stall.
REQ-022 Transfer out: result consumed when out_valid && out_ready; outputs SHALL remain stable while out_valid && !out_ready.
REQ-023 ovf SHALL equal (carry into MSB) XOR c_out of the full WIDTH-bit operation; only meaningful when out_valid=1.
REQ-024 Result SHALL be modulo 2^WIDTH; wrap-around sets c_out, never saturates.
REQ-025 Each stage SHALL carry its own valid bit; bubbles (in_valid=0 cycles) SHALL propagate as out_valid=0 and not stall the pipe.
REQ-026 Simultaneous accept-in and consume-out in one cycle SHALL both occur; order of results SHALL equal order of acceptance.
REQ-027 in_ready SHALL be a function of registered out_valid and out_ready only (no dependency on in_valid).

Reset
REQ-028 When RST_N=0 at a CLK edge: all stage valid bits, out_valid, s, c_out, ovf SHALL become 0.
REQ-029 Reset mid-operation SHALL discard all in-flight sets; no result from them SHALL ever appear.
REQ-030 in_ready SHALL be 1 the first cycle after reset release; the first post-reset operand set is accepted normally.
REQ-031 Operand inputs during reset SHALL be ignored.

Verification (WIDTH=16, SEG=4, NSTG=4)
REQ-032 Add: a=0x1234, b=0x0FCD, c_in=1, sub=0, out_ready=1 -> 4 cycles later out_valid=1, s=0x2202, c_out=0, ovf=0.
REQ-033 Carry ripple/wrap: a=0xFFFF, b=0x0001, c_in=0 -> s=0x0000, c_out=1, ovf=0; a=0x7FFF, b=0x0001 -> s=0x8000, c_out=0, ovf=1.
REQ-034 Sub: a=0x0005, b=0x0007, sub=1, c_in=1 -> s=0xFFFE, c_out=0; a=0x8000, b=0x0001, sub=1 -> s=0x7FFF, c_out=1, ovf=1.
REQ-035 Back-pressure: stream 8 sets back-to-back, hold out_ready=0 for 3 cycles after first out_valid -> in_ready=0 and s held for those 3 cycles, all 8 results emerge in order, none lost or duplicated.
REQ-036 Reset mid-flight: accept 3 sets, assert RST_N=0 one cycle, release -> out_valid stays 0 until a new set is accepted, which appears 4 cycles after acceptance.
REQ-037 Random: 10k random a, b, c_in, sub, in_valid, out_ready -> every result matches reference model, in order.

Source files
------------

// File: rtl/add_sub_pipe_if.sv
// Operand/result handshake bundle for add_sub_pipe.
// The producer/consumer side uses master; the pipeline itself uses slave.
interface add_sub_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             c_out;
    logic             ovf;

    modport master (
        output in_valid, a, b, c_in, sub, out_ready,
        input  in_ready, out_valid, s, c_out, ovf
    );

    modport slave (
        input  in_valid, a, b, c_in, sub, out_ready,
        output in_ready, out_valid, s, c_out, ovf
    );
endinterface

// File: rtl/add_sub_pipe.sv
// Segmented ripple adder/subtractor: SEG bits per stage, NSTG = WIDTH/SEG stages,
// valid/ready flow with a global stall that freezes every stage.
module add_sub_pipe #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic          CLK,
    input  logic          RST_N,
    add_sub_pipe_if.slave bus
);
    localparam int NSTG = WIDTH / SEG;

    logic stall;
    logic ovf_d, ovf_q;

    // Each stage word is {a_rem, bx_rem, sum_done}: the segment adder overwrites the
    // low bx segment in place and the consumed a segment is squeezed out, so the
    // word shrinks by SEG bits per stage and ends up as exactly the WIDTH-bit sum.
    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        localparam int RW = WIDTH - k * SEG;
        localparam int IW = WIDTH + RW;
        localparam int OW = IW - SEG;
        localparam int BP = k * SEG;
        localparam int AP = BP + RW;
        localparam logic [IW-1:0] LO_MASK = (IW'(1) << AP) - IW'(1);

        logic [IW-1:0] pk_in;
        logic [IW-1:0] merged;
        logic          cy_in;
        logic          vld_in;
        logic [SEG:0]  seg_add;
        logic [OW-1:0] pk_d, pk_q;
        logic          cy_d, cy_q;
        logic          vld_d, vld_q;

        if (k == 0) begin : g_src
            assign pk_in  = {bus.a, (bus.sub ? ~bus.b : bus.b)};
            assign cy_in  = bus.sub | bus.c_in;
            assign vld_in = bus.in_valid;
        end else begin : g_src
            assign pk_in  = g_stg[k-1].pk_q;
            assign cy_in  = g_stg[k-1].cy_q;
            assign vld_in = g_stg[k-1].vld_q;
        end

        always_comb begin
            seg_add = {1'b0, pk_in[AP +: SEG]} + {1'b0, pk_in[BP +: SEG]}
                    + {{SEG{1'b0}}, cy_in};
            merged = pk_in;
            merged[BP +: SEG] = seg_add[SEG-1:0];
            pk_d  = pk_q;
            cy_d  = cy_q;
            vld_d = vld_q;
            if (!stall) begin
                pk_d  = OW'((merged & LO_MASK) | ((merged >> (AP + SEG)) << AP));
                cy_d  = seg_add[SEG];
                vld_d = vld_in;
            end
        end

        always_ff @(posedge CLK) begin
            if (!RST_N) begin
                pk_q  <= '0;
                cy_q  <= 1'b0;
                vld_q <= 1'b0;
            end else begin
                pk_q  <= pk_d;
                cy_q  <= cy_d;
                vld_q <= vld_d;
            end
        end
    end

    assign stall = g_stg[NSTG-1].vld_q & ~bus.out_ready;

    // Carry into the MSB is recovered from the MSB sum bit and the two MSB operand bits.
    always_comb begin
        ovf_d = ovf_q;
        if (!stall) begin
            ovf_d = g_stg[NSTG-1].seg_add[SEG-1]
                  ^ g_stg[NSTG-1].pk_in[WIDTH+SEG-1]
                  ^ g_stg[NSTG-1].pk_in[WIDTH-1]
                  ^ g_stg[NSTG-1].seg_add[SEG];
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.in_ready  = ~stall;
    assign bus.out_valid = g_stg[NSTG-1].vld_q;
    assign bus.s         = g_stg[NSTG-1].pk_q;
    assign bus.c_out     = g_stg[NSTG-1].cy_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_add_sub_pipe.sv
// Bench for add_sub_pipe: directed corner sets, back-pressure, mid-flight reset and
// a long random run, all scored against an integer-arithmetic model queue.
module tb_add_sub_pipe;
    localparam int W    = 16;
    localparam int S    = 4;
    localparam int NSTG = W / S;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         o;
        int           cyc;
        int           stl;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    add_sub_pipe_if #(.WIDTH(W)) bus ();
    add_sub_pipe #(.WIDTH(W), .SEG(S)) dut (.CLK(clk), .RST_N(rst_n), .bus(bus));

    exp_t         exp_q[$];
    int           n_cmp = 0;
    int           n_err = 0;
    int           n_vec = 0;
    int           cyc = 0;
    int           stall_cnt = 0;
    logic         lit_en = 1'b0;
    logic [W-1:0] lit_s = '0;
    logic         lit_c = 1'b0;
    logic         lit_o = 1'b0;
    logic         prev_stall = 1'b0;
    logic         prev_rst = 1'b1;
    logic [W-1:0] held_s = '0;
    logic         held_c = 1'b0;
    logic         held_o = 1'b0;

    // Result from plain unsigned/signed integer arithmetic: {c_out, ovf, s}.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin, input logic sub);
        int ua, ub, sa, sb, ures, sres;
        logic c, o;
        logic [W-1:0] r;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sub) begin
            ures = ua - ub;
            sres = sa - sb;
            c = (ua >= ub);
        end else begin
            ures = ua + ub + int'(cin);
            sres = sa + sb + int'(cin);
            c = (ures >= (1 << W));
        end
        r = ures[W-1:0];
        o = (sres > (1 << (W - 1)) - 1) || (sres < -(1 << (W - 1)));
        return {c, o, r};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, required %0h", nm, cyc, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic [W+1:0] m;
        logic st;
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            prev_stall = 1'b0;
            prev_rst = 1'b1;
        end else begin
            if (prev_rst) begin
                chk("reset_out_valid", 32'(bus.out_valid), 32'(0));
                chk("reset_s", 32'(bus.s), 32'(0));
                chk("reset_c_out", 32'(bus.c_out), 32'(0));
                chk("reset_ovf", 32'(bus.ovf), 32'(0));
                chk("reset_in_ready", 32'(bus.in_ready), 32'(1));
            end
            prev_rst = 1'b0;
            st = bus.out_valid && !bus.out_ready;
            chk("in_ready", 32'(bus.in_ready), 32'(!st));
            if (prev_stall) begin
                chk("hold_out_valid", 32'(bus.out_valid), 32'(1));
                chk("hold_s", 32'(bus.s), 32'(held_s));
                chk("hold_c_out", 32'(bus.c_out), 32'(held_c));
                chk("hold_ovf", 32'(bus.ovf), 32'(held_o));
            end
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("out_valid_without_pending_set", 32'(bus.out_valid), 32'(0));
                end else if (bus.out_ready) begin
                    e = exp_q.pop_front();
                    chk("s", 32'(bus.s), 32'(e.s));
                    chk("c_out", 32'(bus.c_out), 32'(e.c));
                    chk("ovf", 32'(bus.ovf), 32'(e.o));
                    chk("latency", 32'(cyc - e.cyc), 32'(NSTG + stall_cnt - e.stl));
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                m = model(bus.a, bus.b, bus.c_in, bus.sub);
                if (lit_en) begin
                    chk("model_s", 32'(m[W-1:0]), 32'(lit_s));
                    chk("model_c_out", 32'(m[W+1]), 32'(lit_c));
                    chk("model_ovf", 32'(m[W]), 32'(lit_o));
                end
                e.s = m[W-1:0];
                e.c = m[W+1];
                e.o = m[W];
                e.cyc = cyc;
                e.stl = stall_cnt;
                exp_q.push_back(e);
                n_vec++;
            end
            if (st) begin
                stall_cnt++;
                held_s = bus.s;
                held_c = bus.c_out;
                held_o = bus.ovf;
            end
            prev_stall = st;
        end
    end

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic sub, input logic le, input logic [W-1:0] ls,
                        input logic lc, input logic lo);
        bit done;
        done = 1'b0;
        bus.a = a;
        bus.b = b;
        bus.c_in = cin;
        bus.sub = sub;
        bus.in_valid = 1'b1;
        lit_en = le;
        lit_s = ls;
        lit_c = lc;
        lit_o = lo;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            done = bus.in_ready;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        lit_en = 1'b0;
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout at cycle %0d: in_ready stayed 0, required 1 within 50 cycles", cyc);
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.c_in = 1'b0;
        bus.sub = 1'b0;
        bus.out_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        send(16'h1234, 16'h0FCD, 1'b1, 1'b0, 1'b1, 16'h2202, 1'b0, 1'b0);
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1);
        send(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        send(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        idle(8);

        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                         1'b0, 16'h0, 1'b0, 1'b0);
            end
            begin
                bit seen;
                seen = 1'b0;
                for (int t = 0; t < 40 && !seen; t++) begin
                    @(posedge clk);
                    #1;
                    seen = bus.out_valid;
                end
                if (!seen) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL bp_first_output at cycle %0d: out_valid stayed 0, required 1", cyc);
                end else begin
                    bus.out_ready = 1'b0;
                    repeat (3) begin
                        @(posedge clk);
                        #1;
                    end
                    bus.out_ready = 1'b1;
                end
            end
        join
        idle(12);

        for (int i = 0; i < 3; i++)
            send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                 1'b0, 16'h0, 1'b0, 1'b0);
        rst_n = 1'b0;
        bus.in_valid = 1'b1;
        bus.a = 16'hABCD;
        bus.b = 16'h1357;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        idle(6);
        send(16'h1234, 16'h0FCD, 1'b1, 1'b0, 1'b1, 16'h2202, 1'b0, 1'b0);
        idle(8);

        for (int i = 0; i < 10000; i++) begin
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.a = ($urandom_range(0, 7) == 0) ? 16'h7FFF : 16'($urandom);
            bus.b = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
            bus.c_in = 1'($urandom);
            bus.sub = 1'($urandom);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        idle(20);
        chk("drain_queue_empty", 32'(exp_q.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
